cp0_responder: RTL and testbench
================================

CP0_RESPONDER -- requirements
Module: cp0_responder

Interface
REQ-001 Parameter EXC_NONE, default 5'b11111, meaning ExcCodeIn value that signals no exception.
REQ-002 Parameter PRID_VAL, default 32'h0000_4D49, meaning read-only processor ID value.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A1  input  5  CP0 read register number (mfc0).
REQ-006 A2  input  5  CP0 write register number (mtc0).
REQ-007 DIn  input  32  mtc0 write data.
REQ-008 We  input  1  mtc0 write enable.
REQ-009 PC  input  32  PC of the instruction currently in M stage.
REQ-010 BD  input  1  M-stage instruction is in a branch delay slot.
REQ-011 ExcCodeIn  input  5  M-stage exception code; EXC_NONE when none.
REQ-012 HWInt  input  6  hardware interrupt lines [7:2].
REQ-013 EXLClr  input  1  eret retiring in M stage.
REQ-014 IntReq  output  1  take exception/interrupt this cycle; flush pipeline, redirect to handler.
REQ-015 EPC  output  32  current EPC register value.
REQ-016 DOut  output  32  combinational read data for register A1.

Function
REQ-017 The block SHALL hold SR (reg 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-018 The block SHALL hold Cause (reg 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-019 The block SHALL hold EPC (reg 14, 32 bits) and return PRID_VAL for reg 15; all other register numbers SHALL read 32'h0.
REQ-020 IP SHALL be loaded from HWInt every cycle that reset is low, regardless of other events.
REQ-021 Interrupt pending SHALL be |(HWInt & IM) & IE & ~EXL, using current-cycle HWInt.
REQ-022 Exception pending SHALL be (ExcCodeIn != EXC_NONE) & ~EXL.
REQ-023 IntReq SHALL be combinational: interrupt pending OR exception pending.
REQ-024 On an IntReq edge, the block SHALL set EXL=1, Cause.BD=BD, and EPC = BD ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
REQ-025 On an IntReq edge, Cause.ExcCode SHALL be 5'd0 if interrupt pending, else ExcCodeIn; interrupt has priority over exception.
REQ-026 When IntReq=1, an mtc0 write (We) in the same cycle SHALL be discarded.
REQ-027 When IntReq=0 and We=1, A2=12 SHALL write IM, EXL, IE from DIn; A2=14 SHALL write EPC={DIn[31:2],2'b00}; A2=13, 15 and others SHALL be ignored.
REQ-028 When EXLClr=1 and IntReq=0, EXL SHALL clear to 0; if We targets SR in the same cycle, EXLClr SHALL win for EXL only.
REQ-029 DOut SHALL reflect register state before the current edge (no write-to-read bypass); the pipeline forwards mtc0 data.
REQ-030 EPC output SHALL equal the EPC register, updated one cycle after the IntReq edge or mtc0 write.
REQ-031 While EXL=1, no nested exception or interrupt SHALL be taken; ExcCodeIn and HWInt SHALL affect only IP.

Reset
REQ-032 On reset=1 at a clock edge: IM=6'h3F, EXL=0, IE=1, BD=0, IP=0, ExcCode=0, EPC=32'h0000_3000.
REQ-033 Reset SHALL override IntReq, We and EXLClr in the same cycle; IntReq SHALL still be combinational during reset, with side effects suppressed.

Verification
REQ-034 After reset, HWInt=6'b000100, one clock -> IntReq=1 that cycle; next cycle Cause=32'h0000_1000, EXL=1, EPC=PC.
REQ-035 ExcCodeIn=5'd4, BD=1, PC=32'h0000_3010 -> IntReq=1; after edge Cause[31]=1, Cause[6:2]=4, EPC=32'h0000_300C.
REQ-036 HWInt=6'b000001 and ExcCodeIn=5'd5 together -> Cause.ExcCode=0 (interrupt wins).
REQ-037 EXL=1 with ExcCodeIn=5'd4 -> IntReq=0 and EPC unchanged; EXLClr=1 for one cycle -> EXL=0 and pending interrupt now raises IntReq.
REQ-038 Write mtc0 A2=12, DIn=32'h0000_0401 -> SR reads 32'h0000_0401; same-cycle IntReq -> SR unchanged.
REQ-039 Write mtc0 A2=14, DIn=32'h0000_3457 -> EPC=32'h0000_3454; A1=15 -> DOut=PRID_VAL; A1=3 -> DOut=0.

Source files
------------

// File: rtl/cp0_responder.sv
// MIPS-style coprocessor 0 slice: SR, Cause, EPC and PRId, with combinational
// exception/interrupt request and mfc0 read port.
module cp0_responder #(
  parameter logic [4:0]  EXC_NONE = 5'b11111,
  parameter logic [31:0] PRID_VAL = 32'h0000_4D49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_aligned;

  assign int_pend   = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_pend   = (ExcCodeIn != EXC_NONE) & ~exl_q;
  assign IntReq     = int_pend | exc_pend;
  assign pc_aligned = PC & 32'hFFFF_FFFC;

  always_comb begin
    // NOTE: every next-state variable takes its hold value first so no path
    // through the branches below can leave one unassigned and infer a latch.
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;

    if (IntReq) begin
      // Taking the exception discards any same-cycle mtc0 and eret.
      exl_d      = 1'b1;
      bd_d       = BD;
      epc_d      = BD ? pc_aligned - 32'd4 : pc_aligned;
      exc_code_d = int_pend ? 5'd0 : ExcCodeIn;
    end else begin
      if (We) begin
        if (A2 == REG_SR) begin
          im_d  = DIn[15:10];
          exl_d = DIn[1];
          ie_d  = DIn[0];
        end else if (A2 == REG_EPC) begin
          epc_d = {DIn[31:2], 2'b00};
        end
      end
      if (EXLClr) exl_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values computed before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'h3F;
      exl_q      <= 1'b0;
      ie_q       <= 1'b1;
      bd_q       <= 1'b0;
      ip_q       <= 6'h00;
      exc_code_q <= 5'd0;
      epc_q      <= 32'h0000_3000;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  assign EPC = epc_q;

  // Reads see pre-edge state; the pipeline forwards in-flight mtc0 data.
  always_comb begin
    DOut = 32'h0;
    case (A1)
      REG_SR:    DOut = {16'h0, im_q, 8'h0, exl_q, ie_q};
      REG_CAUSE: DOut = {bd_q, 15'h0, ip_q, 3'h0, exc_code_q, 2'b00};
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_responder.sv
// Directed bench for cp0_responder: reset values, interrupt/exception entry,
// EXL masking, eret, mtc0 interaction and read-port decode.
module tb_cp0_responder;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int checks   = 0;
  int failures = 0;

  cp0_responder dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .We        (We),
    .PC        (PC),
    .BD        (BD),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .IntReq    (IntReq),
    .EPC       (EPC),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    A1 = addr;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic req(input logic exp, input string tag);
    #1;
    check(tag, {31'b0, IntReq}, {31'b0, exp});
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 32'h0; We = 1'b0;
    PC = 32'h0000_3000; BD = 1'b0; ExcCodeIn = 5'h1F; HWInt = 6'h00; EXLClr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and read decode
    rd(5'd12, 32'h0000_FC01, "reset_sr");
    rd(5'd13, 32'h0000_0000, "reset_cause");
    rd(5'd14, 32'h0000_3000, "reset_epc_dout");
    check("reset_epc", EPC, 32'h0000_3000);
    req(1'b0, "reset_intreq");
    rd(5'd15, 32'h0000_4D49, "prid");
    rd(5'd3,  32'h0000_0000, "unmapped_reg");

    // Hardware interrupt on line 4
    HWInt = 6'b000100; PC = 32'h0000_3020;
    req(1'b1, "hwint_intreq");
    tick();
    rd(5'd13, 32'h0000_1000, "hwint_cause");
    rd(5'd12, 32'h0000_FC03, "hwint_sr_exl");
    check("hwint_epc", EPC, 32'h0000_3020);
    req(1'b0, "hwint_masked_by_exl");

    // EXL masks exceptions; eret then exposes the still-pending interrupt
    ExcCodeIn = 5'd4; PC = 32'h0000_3030;
    req(1'b0, "exl_masks_exc");
    tick();
    check("exl_epc_hold", EPC, 32'h0000_3020);
    rd(5'd13, 32'h0000_1000, "exl_cause_hold");
    ExcCodeIn = 5'h1F; EXLClr = 1'b1;
    req(1'b0, "eret_cycle_intreq");
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret_sr");
    req(1'b1, "eret_pending_int");
    PC = 32'h0000_3040;
    tick();
    check("reint_epc", EPC, 32'h0000_3040);

    // Exception in a branch delay slot
    HWInt = 6'h00; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    req(1'b0, "idle_intreq");
    ExcCodeIn = 5'd4; BD = 1'b1; PC = 32'h0000_3010;
    req(1'b1, "exc_bd_intreq");
    tick();
    ExcCodeIn = 5'h1F; BD = 1'b0;
    rd(5'd13, 32'h8000_0010, "exc_bd_cause");
    check("exc_bd_epc", EPC, 32'h0000_300C);

    // Interrupt wins over a simultaneous exception
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    HWInt = 6'b000001; ExcCodeIn = 5'd5; PC = 32'h0000_3100;
    req(1'b1, "prio_intreq");
    tick();
    HWInt = 6'h00; ExcCodeIn = 5'h1F;
    rd(5'd13, 32'h0000_0400, "prio_cause");
    check("prio_epc", EPC, 32'h0000_3100);

    // mtc0 SR, then mtc0 SR discarded by a same-cycle interrupt
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    We = 1'b0;
    rd(5'd12, 32'h0000_0401, "mtc0_sr");
    HWInt = 6'b000001; PC = 32'h0000_3200;
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC00;
    req(1'b1, "mtc0_sr_vs_int");
    tick();
    We = 1'b0; HWInt = 6'h00;
    rd(5'd12, 32'h0000_0403, "mtc0_sr_discarded");

    // eret and mtc0 SR together: EXLClr owns EXL, write owns IM/IE
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0C03; EXLClr = 1'b1;
    req(1'b0, "eret_mtc0_intreq");
    tick();
    We = 1'b0; EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0C01, "eret_mtc0_sr");

    // mtc0 EPC with no write-to-read bypass
    We = 1'b1; A2 = 5'd14; DIn = 32'h0000_3457;
    rd(5'd14, 32'h0000_3200, "epc_no_bypass");
    tick();
    We = 1'b0;
    check("mtc0_epc", EPC, 32'h0000_3454);
    rd(5'd14, 32'h0000_3454, "mtc0_epc_dout");

    // mtc0 to Cause is ignored
    We = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    We = 1'b0;
    rd(5'd13, 32'h0000_0000, "mtc0_cause_ignored");

    // Reset overrides a pending interrupt and mtc0
    HWInt = 6'b000001; reset = 1'b1; We = 1'b1; A2 = 5'd14; DIn = 32'h1234_5678;
    req(1'b1, "reset_comb_intreq");
    tick();
    reset = 1'b0; HWInt = 6'h00; We = 1'b0;
    rd(5'd12, 32'h0000_FC01, "reset_ovr_sr");
    rd(5'd13, 32'h0000_0000, "reset_ovr_cause");
    check("reset_ovr_epc", EPC, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
